// File: rtl/onchip_ram_dp.sv
`default_nettype none
// ============================================================================
// Module   : onchip_ram_dp
// Brief    : True dual-port Avalon-MM RAM: byte-enabled writes, 1/2-cycle reads,
//            A-wins write collision resolution, saturating collision counter.
//            Optional per-byte even parity via ONCHIP_RAM_PARITY_EN.
// Revision : 1.0
// ============================================================================
module onchip_ram_dp #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 10,
    parameter int READ_LATENCY = 1,
    parameter int COLL_CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clken,
    input  logic                  reset_req,
    input  logic [ADDR_W-1:0]     a_address,
    input  logic [DATA_W/8-1:0]   a_byteenable,
    input  logic                  a_chipselect,
    input  logic                  a_read,
    input  logic                  a_write,
    input  logic [DATA_W-1:0]     a_writedata,
    output logic [DATA_W-1:0]     a_readdata,
    output logic                  a_readdatavalid,
    input  logic [ADDR_W-1:0]     b_address,
    input  logic [DATA_W/8-1:0]   b_byteenable,
    input  logic                  b_chipselect,
    input  logic                  b_read,
    input  logic                  b_write,
    input  logic [DATA_W-1:0]     b_writedata,
    output logic [DATA_W-1:0]     b_readdata,
    output logic                  b_readdatavalid,
`ifdef ONCHIP_RAM_PARITY_EN
    output logic                  a_parity_err,
    output logic                  b_parity_err,
`endif
    output logic [COLL_CNT_W-1:0] coll_count,
    output logic                  coll_pulse
);

    localparam int c_NB    = DATA_W / 8;
    localparam int c_DEPTH = 2 ** ADDR_W;
`ifdef ONCHIP_RAM_PARITY_EN
    localparam int c_MW    = DATA_W + c_NB;   // parity bits live above the data
`else
    localparam int c_MW    = DATA_W;
`endif

    logic                        w_en;
    logic [1:0][ADDR_W-1:0]      w_addr;
    logic [1:0][c_NB-1:0]        w_be;
    logic [1:0][DATA_W-1:0]      w_wd;
    logic [1:0]                  w_rd_acc;
    logic [1:0]                  w_wr_acc;
    logic [1:0][c_MW-1:0]        w_rd_q;
    logic [1:0]                  w_rd_vld;
    logic                        w_coll;

    logic [c_MW-1:0]             r_mem [c_DEPTH];
    logic [COLL_CNT_W-1:0]       r_coll_count;
    logic                        r_coll_pulse;

    assign w_en     = clken & ~reset_req;
    assign w_addr   = {b_address, a_address};
    assign w_be     = {b_byteenable, a_byteenable};
    assign w_wd     = {b_writedata, a_writedata};
    assign w_rd_acc = {w_en & b_chipselect & b_read,  w_en & a_chipselect & a_read};
    assign w_wr_acc = {w_en & b_chipselect & b_write, w_en & a_chipselect & a_write};
    assign w_coll   = w_wr_acc[0] & w_wr_acc[1] & (w_addr[0] == w_addr[1]);

    // Port B is applied first so that port A's lanes override on a collision.
    always_ff @(posedge clk) begin
        for (int p = 1; p >= 0; p--) begin
            for (int i = 0; i < c_NB; i++) begin
                if (w_wr_acc[p] && w_be[p][i]) begin
                    r_mem[w_addr[p]][8*i +: 8] <= w_wd[p][8*i +: 8];
`ifdef ONCHIP_RAM_PARITY_EN
                    r_mem[w_addr[p]][DATA_W+i] <= ^w_wd[p][8*i +: 8];
`endif
                end
            end
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic [c_MW-1:0] r_s1_q;
        logic            r_s1_vld;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_s1_q   <= '0;
                r_s1_vld <= 1'b0;
            end else if (w_en) begin
                r_s1_vld <= w_rd_acc[p];
                if (w_rd_acc[p]) begin
                    r_s1_q <= r_mem[w_addr[p]];
                end
            end
        end

        if (READ_LATENCY == 2) begin : g_lat2
            logic [c_MW-1:0] r_s2_q;
            logic            r_s2_vld;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_s2_q   <= '0;
                    r_s2_vld <= 1'b0;
                end else if (w_en) begin
                    r_s2_vld <= r_s1_vld;
                    if (r_s1_vld) begin
                        r_s2_q <= r_s1_q;
                    end
                end
            end

            assign w_rd_q[p]   = r_s2_q;
            assign w_rd_vld[p] = r_s2_vld;
        end else begin : g_lat1
            assign w_rd_q[p]   = r_s1_q;
            assign w_rd_vld[p] = r_s1_vld;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_coll_count <= '0;
            r_coll_pulse <= 1'b0;
        end else if (w_en) begin
            r_coll_pulse <= w_coll;
            if (w_coll && (r_coll_count != {COLL_CNT_W{1'b1}})) begin
                r_coll_count <= r_coll_count + COLL_CNT_W'(1);
            end
        end
    end

    assign a_readdata      = w_rd_q[0][DATA_W-1:0];
    assign b_readdata      = w_rd_q[1][DATA_W-1:0];
    assign a_readdatavalid = w_rd_vld[0] & w_en;
    assign b_readdatavalid = w_rd_vld[1] & w_en;
    assign coll_count      = r_coll_count;
    assign coll_pulse      = r_coll_pulse & w_en;

`ifdef ONCHIP_RAM_PARITY_EN
    logic [1:0] w_par_err;

    for (genvar p = 0; p < 2; p++) begin : g_par
        logic [c_NB-1:0] w_mis;
        for (genvar i = 0; i < c_NB; i++) begin : g_lane
            assign w_mis[i] = (^w_rd_q[p][8*i +: 8]) ^ w_rd_q[p][DATA_W+i];
        end
        assign w_par_err[p] = |w_mis;
    end

    assign a_parity_err = a_readdatavalid & w_par_err[0];
    assign b_parity_err = b_readdatavalid & w_par_err[1];
`endif

endmodule
`default_nettype wire

// File: tb/tb_onchip_ram_dp.sv
`default_nettype none
// ============================================================================
// Module   : tb_onchip_ram_dp
// Brief    : Directed bench for onchip_ram_dp; two instances (latency 1 with a
//            16-bit counter, latency 2 with a 4-bit counter) share all inputs.
// Revision : 1.0
// ============================================================================
module tb_onchip_ram_dp;

    logic        clk = 1'b0;
    logic        reset_n, clken, reset_req;
    logic [9:0]  a_address, b_address;
    logic [3:0]  a_byteenable, b_byteenable;
    logic        a_chipselect, a_read, a_write, b_chipselect, b_read, b_write;
    logic [31:0] a_writedata, b_writedata;

    logic [31:0] d1_a_rd, d1_b_rd, d2_a_rd, d2_b_rd;
    logic        d1_a_v, d1_b_v, d2_a_v, d2_b_v;
    logic [15:0] d1_cc;
    logic [3:0]  d2_cc;
    logic        d1_cp, d2_cp;

    int n_vec = 0;
    int n_err = 0;
    int exp_coll = 0;

    logic [31:0] mm [1024];
    logic [31:0] q1a [$];
    logic [31:0] q1b [$];
    logic [31:0] q2a [$];
    logic [31:0] q2b [$];

    always #5 clk = ~clk;

    onchip_ram_dp #(.DATA_W(32), .ADDR_W(10), .READ_LATENCY(1), .COLL_CNT_W(16)) dut1 (
        .clk(clk), .reset_n(reset_n), .clken(clken), .reset_req(reset_req),
        .a_address(a_address), .a_byteenable(a_byteenable), .a_chipselect(a_chipselect),
        .a_read(a_read), .a_write(a_write), .a_writedata(a_writedata),
        .a_readdata(d1_a_rd), .a_readdatavalid(d1_a_v),
        .b_address(b_address), .b_byteenable(b_byteenable), .b_chipselect(b_chipselect),
        .b_read(b_read), .b_write(b_write), .b_writedata(b_writedata),
        .b_readdata(d1_b_rd), .b_readdatavalid(d1_b_v),
        .coll_count(d1_cc), .coll_pulse(d1_cp)
    );

    onchip_ram_dp #(.DATA_W(32), .ADDR_W(10), .READ_LATENCY(2), .COLL_CNT_W(4)) dut2 (
        .clk(clk), .reset_n(reset_n), .clken(clken), .reset_req(reset_req),
        .a_address(a_address), .a_byteenable(a_byteenable), .a_chipselect(a_chipselect),
        .a_read(a_read), .a_write(a_write), .a_writedata(a_writedata),
        .a_readdata(d2_a_rd), .a_readdatavalid(d2_a_v),
        .b_address(b_address), .b_byteenable(b_byteenable), .b_chipselect(b_chipselect),
        .b_read(b_read), .b_write(b_write), .b_writedata(b_writedata),
        .b_readdata(d2_b_rd), .b_readdatavalid(d2_b_v),
        .coll_count(d2_cc), .coll_pulse(d2_cp)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic mwrite(input logic [9:0] adr, input logic [3:0] be, input logic [31:0] wd);
        for (int i = 0; i < 4; i++) begin
            if (be[i]) mm[adr][8*i +: 8] = wd[8*i +: 8];
        end
    endtask

    // Drive one request cycle; expectations and the memory model advance only if enabled.
    task automatic drive(input logic ar, input logic aw, input logic [9:0] aa,
                         input logic [3:0] abe, input logic [31:0] awd,
                         input logic br, input logic bw, input logic [9:0] ba,
                         input logic [3:0] bbe, input logic [31:0] bwd);
        a_chipselect = ar | aw; a_read = ar; a_write = aw;
        a_address = aa; a_byteenable = abe; a_writedata = awd;
        b_chipselect = br | bw; b_read = br; b_write = bw;
        b_address = ba; b_byteenable = bbe; b_writedata = bwd;
        if (clken && !reset_req) begin
            if (ar) begin q1a.push_back(mm[aa]); q2a.push_back(mm[aa]); end
            if (br) begin q1b.push_back(mm[ba]); q2b.push_back(mm[ba]); end
            if (aw && bw && aa == ba) exp_coll++;
            if (bw) mwrite(ba, bbe, bwd);
            if (aw) mwrite(aa, abe, awd);
        end
        @(posedge clk); #1;
    endtask

    task automatic set_idle();
        a_chipselect = 1'b0; a_read = 1'b0; a_write = 1'b0;
        b_chipselect = 1'b0; b_read = 1'b0; b_write = 1'b0;
    endtask

    task automatic idle(input int n);
        set_idle();
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic mon(input string tag, input logic v, input logic [31:0] d, input int k);
        logic [31:0] e;
        int sz;
        if (v !== 1'b1) return;
        case (k)
            0: sz = q1a.size();
            1: sz = q1b.size();
            2: sz = q2a.size();
            default: sz = q2b.size();
        endcase
        n_vec++;
        assert (sz != 0) else begin
            n_err++;
            $error("FAIL %s_unexpected_valid: observed valid with data %h, required no valid", tag, d);
        end
        if (sz != 0) begin
            case (k)
                0: e = q1a.pop_front();
                1: e = q1b.pop_front();
                2: e = q2a.pop_front();
                default: e = q2b.pop_front();
            endcase
            check({tag, "_rdata"}, d, e);
        end
    endtask

    always @(negedge clk) begin
        mon("d1_a", d1_a_v, d1_a_rd, 0);
        mon("d1_b", d1_b_v, d1_b_rd, 1);
        mon("d2_a", d2_a_v, d2_a_rd, 2);
        mon("d2_b", d2_b_v, d2_b_rd, 3);
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: observed no end of test, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0; clken = 1'b1; reset_req = 1'b0;
        a_address = '0; a_byteenable = '0; a_writedata = '0;
        b_address = '0; b_byteenable = '0; b_writedata = '0;
        set_idle();
        repeat (2) @(posedge clk);
        #1;
        check("rst_d1_a_rdata", d1_a_rd, 32'h0);
        check("rst_d2_b_rdata", d2_b_rd, 32'h0);
        check("rst_d1_a_valid", 32'(d1_a_v), 32'h0);
        check("rst_d2_b_valid", 32'(d2_b_v), 32'h0);
        check("rst_d1_count",   32'(d1_cc), 32'h0);
        check("rst_d1_pulse",   32'(d1_cp), 32'h0);
        reset_n = 1'b1;
        idle(1);

        // Single write then read, with latency observed on both instances
        drive(0, 1, 10'h005, 4'hF, 32'hDEADBEEF, 0, 0, 10'h0, 4'h0, 32'h0);
        drive(1, 0, 10'h005, 4'h0, 32'h0,        0, 0, 10'h0, 4'h0, 32'h0);
        set_idle();
        @(negedge clk);
        check("lat1_d1_valid_c1", 32'(d1_a_v), 32'h1);
        check("lat2_d2_valid_c1", 32'(d2_a_v), 32'h0);
        @(negedge clk);
        check("lat1_d1_valid_c2", 32'(d1_a_v), 32'h0);
        check("lat2_d2_valid_c2", 32'(d2_a_v), 32'h1);
        @(negedge clk);
        check("hold_d1_rdata", d1_a_rd, 32'hDEADBEEF);

        // Byte-lane merge
        drive(0, 1, 10'h005, 4'h5, 32'h11223344, 0, 0, 10'h0, 4'h0, 32'h0);
        drive(1, 0, 10'h005, 4'h0, 32'h0,        0, 0, 10'h0, 4'h0, 32'h0);
        set_idle();
        @(negedge clk);
        check("merge_d1_rdata", d1_a_rd, 32'hDE22BE44);
        @(negedge clk);
        check("merge_d2_rdata", d2_a_rd, 32'hDE22BE44);

        // Read during write: cross-port and same-port both return the old word
        drive(0, 1, 10'h010, 4'hF, 32'h0,        0, 0, 10'h0,   4'h0, 32'h0);
        drive(0, 1, 10'h010, 4'hF, 32'h12345678, 1, 0, 10'h010, 4'h0, 32'h0);
        drive(0, 0, 10'h0,   4'h0, 32'h0,        1, 0, 10'h010, 4'h0, 32'h0);
        drive(1, 1, 10'h010, 4'hF, 32'hCAFEF00D, 0, 0, 10'h0,   4'h0, 32'h0);
        drive(1, 0, 10'h010, 4'h0, 32'h0,        0, 0, 10'h0,   4'h0, 32'h0);
        idle(3);

        // Write collision
        drive(0, 1, 10'h3FF, 4'h3, 32'hAAAAAAAA, 0, 1, 10'h3FF, 4'hF, 32'hBBBBBBBB);
        set_idle();
        @(negedge clk);
        check("coll_d1_pulse", 32'(d1_cp), 32'h1);
        check("coll_d2_pulse", 32'(d2_cp), 32'h1);
        check("coll_d1_count", 32'(d1_cc), 32'h1);
        @(negedge clk);
        check("coll_d1_pulse_end", 32'(d1_cp), 32'h0);

        // Zero-byteenable collision counts; pulse held across a freeze
        drive(0, 1, 10'h3FD, 4'h0, 32'h12121212, 0, 1, 10'h3FD, 4'hF, 32'h77777777);
        reset_req = 1'b1;
        drive(0, 1, 10'h3FD, 4'hF, 32'h11111111, 0, 1, 10'h3FD, 4'hF, 32'h22222222);
        set_idle();
        @(negedge clk);
        check("frz_d1_pulse_gated", 32'(d1_cp), 32'h0);
        check("frz_d1_count", 32'(d1_cc), 32'(exp_coll));
        @(posedge clk); #1;
        reset_req = 1'b0;
        @(negedge clk);
        check("frz_d1_pulse_release", 32'(d1_cp), 32'h1);

        // Different addresses do not collide
        drive(0, 1, 10'h030, 4'hF, 32'h30303030, 0, 1, 10'h031, 4'hF, 32'h31313131);
        set_idle();
        @(negedge clk);
        check("nocoll_d1_pulse", 32'(d1_cp), 32'h0);
        check("nocoll_d1_count", 32'(d1_cc), 32'(exp_coll));

        // Saturation of the narrow counter
        for (int i = 0; i < 20; i++)
            drive(0, 1, 10'h3FC, 4'hF, 32'h0A0A0A0A + i, 0, 1, 10'h3FC, 4'hF, 32'h0B0B0B0B);
        set_idle();
        @(negedge clk);
        check("sat_d1_count", 32'(d1_cc), 32'(exp_coll));
        check("sat_d2_count", 32'(d2_cc), 32'hF);

        drive(1, 0, 10'h3FF, 4'h0, 32'h0, 1, 0, 10'h3FD, 4'h0, 32'h0);
        drive(1, 0, 10'h3FC, 4'h0, 32'h0, 1, 0, 10'h030, 4'h0, 32'h0);
        drive(1, 0, 10'h031, 4'h0, 32'h0, 0, 0, 10'h0,   4'h0, 32'h0);
        idle(3);

        // Streamed reads interrupted by a clken gap
        for (int i = 0; i < 4; i++)
            drive(0, 1, 10'h020 + 10'(i), 4'hF, 32'hC0DE0000 + i, 0, 0, 10'h0, 4'h0, 32'h0);
        for (int i = 0; i < 4; i++)
            drive(1, 0, 10'h020 + 10'(i), 4'h0, 32'h0, 0, 0, 10'h0, 4'h0, 32'h0);
        set_idle();
        clken = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("gap_d1_a_valid", 32'(d1_a_v), 32'h0);
            check("gap_d2_a_valid", 32'(d2_a_v), 32'h0);
        end
        @(posedge clk); #1;
        clken = 1'b1;
        idle(4);
        check("gap_d1_drained", 32'(q1a.size()), 32'h0);
        check("gap_d2_drained", 32'(q2a.size()), 32'h0);

        // Asynchronous reset with a read in flight
        drive(1, 0, 10'h005, 4'h0, 32'h0, 0, 0, 10'h0, 4'h0, 32'h0);
        set_idle();
        reset_n = 1'b0;
        #1;
        q1a.delete(); q2a.delete();
        check("arst_d1_a_valid", 32'(d1_a_v), 32'h0);
        check("arst_d1_a_rdata", d1_a_rd, 32'h0);
        check("arst_d2_count",   32'(d2_cc), 32'h0);
        idle(2);
        reset_n = 1'b1;
        idle(4);
        drive(1, 0, 10'h005, 4'h0, 32'h0, 1, 0, 10'h3FF, 4'h0, 32'h0);
        idle(4);
        check("end_q1a_empty", 32'(q1a.size()), 32'h0);
        check("end_q1b_empty", 32'(q1b.size()), 32'h0);
        check("end_q2a_empty", 32'(q2a.size()), 32'h0);
        check("end_q2b_empty", 32'(q2b.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/onchip_ram_dp.md
Name: onchip_ram_dp

Overview:
- Parametrised true dual-port on-chip RAM with two independent Avalon-MM slave ports, A and B, sharing one clock.
- Each port has byte-enabled writes, pipelined reads with selectable latency, `readdatavalid` signalling and global clock-enable/freeze gating.
- Adds deterministic collision resolution between the ports and a saturating collision counter.
- Replaces the fixed 32x1024 single-port RAM in the soft-processor subsystem as program/data memory shared between CPU and DMA.

Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8.
- ADDR_W, 10, word address width; DEPTH = 2**ADDR_W words.
- READ_LATENCY, 1, cycles from accepted read to `readdatavalid`; legal values are 1 or 2.
- COLL_CNT_W, 16, width of the collision counter.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- clken  in  1  global clock enable.
- reset_req  in  1  reset-request freeze; while high the block is gated as if `clken`=0.
- a_address  in  ADDR_W  port A word address.
- a_byteenable  in  DATA_W/8  port A byte lanes.
- a_chipselect  in  1  port A select.
- a_read  in  1  port A read strobe.
- a_write  in  1  port A write strobe.
- a_writedata  in  DATA_W  port A write data.
- a_readdata  out  DATA_W  port A read data.
- a_readdatavalid  out  1  port A read data valid.
- b_address, b_byteenable, b_chipselect, b_read, b_write, b_writedata, b_readdata, b_readdatavalid: same as port A, for port B.
- coll_count  out  COLL_CNT_W  saturating count of same-address write collisions.
- coll_pulse  out  1  one-cycle pulse on each collision.

Behaviour:
- Gating: en = clken & ~reset_req. When en=0:
  - no memory write occurs;
  - read pipelines, counter and `coll_pulse` register hold;
  - both `readdatavalid` outputs and `coll_pulse` are forced to 0.
- Request acceptance: a port's request is accepted on a rising `clk` edge with en=1 and chipselect=1. read and write may both be asserted in the same cycle.
- Write: each byte lane i with byteenable[i]=1 updates mem[address][8i+7:8i]. Lanes with byteenable=0 are unchanged. byteenable=0 writes nothing but still counts as a write for collision purposes.
- Read latency:
  - READ_LATENCY=1: data is registered at the acceptance edge; `readdatavalid`=1 during the following cycle.
  - READ_LATENCY=2: an extra output register stage; `readdatavalid` comes one cycle later.
  - Back-to-back reads give one valid cycle per accepted read, in order, with no bubbles. There is no waitrequest, so every cycle is accepted.
- Read during write:
  - Same port, same cycle: returns the old word.
  - Port B reading an address that port A writes in the same cycle, or the reverse: returns the old word.
- Write collision: both ports write the same address in the same cycle.
  - Per byte, A wins where a_byteenable[i]=1. B's byte is written where a_byteenable[i]=0 and b_byteenable[i]=1.
  - `coll_pulse`=1 during the next en=1 cycle.
  - `coll_count` increments by 1 and saturates at all-ones (no wrap).
- `readdata` holds its last value when not valid.
- Reset (reset_n=0, asynchronous, any time):
  - readdata=0, readdatavalid=0, coll_count=0, coll_pulse=0.
  - In-flight reads are discarded and produce no valid after release.
  - Memory contents are NOT cleared.
- Memory initial contents are undefined unless loaded by the bench.

Optional Feature:
- Macro ONCHIP_RAM_PARITY_EN.
- Defined:
  - Stores one even-parity bit per byte lane, written with the data.
  - On each valid read, the port recomputes parity. Outputs a_parity_err / b_parity_err (1 bit each) are asserted coincident with `readdatavalid` when any lane mismatches.
  - Both outputs reset to 0.
- Undefined: no parity storage; the parity_err ports are absent.

Test Plan:
- Single write then read: A writes 0xDEADBEEF to addr 0x005 with be=0xF, then reads addr 0x005 (READ_LATENCY=1) -> a_readdatavalid=1 exactly one cycle after the read, a_readdata=0xDEADBEEF.
- Byte-lane merge: with 0xDEADBEEF at addr 0x005, write 0x11223344 with be=0x5 and read back -> 0xDE22BE44. Repeat with READ_LATENCY=2 -> valid arrives 2 cycles after the read.
- Write collision: A writes 0xAAAAAAAA with be=0x3 and B writes 0xBBBBBBBB with be=0xF to addr 0x3FF in the same cycle -> mem=0xBBBBAAAA, coll_pulse=1 for one cycle, coll_count=1.
- Saturation: drive 70000 collisions with COLL_CNT_W=16 -> coll_count=0xFFFF.
- Read during write: mem[0x010]=0x0; in one cycle A writes 0x12345678 to 0x010 while B reads 0x010 -> B gets 0x0; the next B read -> 0x12345678.
- Freeze and reset:
  - Stream 4 reads on A, then drop clken for 3 cycles -> no valids during the gap, then the remaining reads complete in order.
  - Assert reset_n=0 with a read in flight -> readdatavalid=0 immediately, no valid after release, memory contents preserved.
